bmp_streamer: RTL and testbench
===============================

BMP_STREAMER -- requirements
Module: bmp_streamer

Interface
REQ-001 Parameter BASE_ADDR, default 54, word address of the first pixel byte in the cropped-image buffer.
REQ-002 Parameter PPM, default 2835, pixels-per-metre value placed in both header resolution fields.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begin streaming one image.
REQ-006 busy  out  1  high from the cycle after an accepted start until done.
REQ-007 done  out  1  one-cycle pulse after the last byte transfers.
REQ-008 xMin, xMax, yMin, yMax  in  11 each  crop window; outer count nx = xMax-xMin, inner count ny = yMax-yMin.
REQ-009 readAddr  out  24  buffer read address.
REQ-010 readdata  in  16  buffer read data; bits [7:0] used; valid exactly 1 cycle after readAddr is presented.
REQ-011 tdata  out  8  stream byte.
REQ-012 tvalid  out  1  tdata valid.
REQ-013 tready  in  1  sink accepts; a transfer occurs when tvalid && tready.
REQ-014 tlast  out  1  high with the final byte of the image.

Function
REQ-015 The window shall be latched on start; later input changes shall not affect the image in progress.
REQ-016 A start while busy shall be ignored.
REQ-017 If xMax<=xMin or yMax<=yMin, the block shall emit no bytes and pulse done 2 cycles after start.
REQ-018 Row = ny*3 pixel bytes; stride S = row rounded up to a multiple of 4 (13-bit); image size I = nx*S (24-bit); file size F = 54+I (32-bit).
REQ-019 Stream order: 54 header bytes, then nx rows, each of ny*3 pixel bytes followed by S-ny*3 zero pad bytes.
REQ-020 Header fields, little-endian: 'B','M'; F(4); 0(4); 54(4); 40(4); ny(4); nx(4); 1(2); 24(2); 0(4); I(4); PPM(4); PPM(4); 0(4); 0(4).
REQ-021 Pixel byte k (0-based, pads excluded) shall be read from BASE_ADDR+k.
REQ-022 States IDLE, HEADER, FETCH, WAIT, EMIT, PAD, DONE; IDLE->HEADER on start; HEADER->FETCH after byte 53 transfers; FETCH presents readAddr; WAIT captures readdata; EMIT holds the byte; EMIT->FETCH, PAD, or DONE on transfer; PAD->FETCH or DONE; DONE->IDLE after 1 cycle.
REQ-023 While tvalid && !tready, tdata, tlast, and state shall hold stable; tvalid shall not drop without a transfer.
REQ-024 tlast shall be asserted only on the final byte: the last pad byte of row nx-1, or its last pixel byte if S = row.
REQ-025 readAddr shall hold its last value outside FETCH.

Reset
REQ-026 On rst_n low at a clock edge: state IDLE, busy 0, done 0, tvalid 0, tlast 0, tdata 0, readAddr BASE_ADDR, counters 0.
REQ-027 Reset mid-stream shall abort the image; tvalid shall be 0 from the next cycle, and no done pulse shall be produced.

Configuration
REQ-028 Macro BMP_STREAMER_HEADER_EN: when defined, behaviour follows REQ-019/020; when undefined, HEADER is skipped, IDLE->FETCH on start, and only pixel and pad bytes are streamed.

Verification
REQ-029 Window 0..2 x 0..2, tready=1, header on -> 70 bytes; bytes 2..5 = 46 00 00 00; bytes 18..25 = 02 00 00 00 02 00 00 00; readAddr 54..65; pad 2 zero bytes per row; tlast on byte 69; done pulse.
REQ-030 Same window, tready toggling 1/0 every cycle -> identical byte sequence; tdata stable during every stall.
REQ-031 xMin=5, xMax=5 -> tvalid never asserted; done 2 cycles after start.
REQ-032 Window 0..1 x 0..4 (ny=4, row 12, S 12) -> 66 bytes, no pad bytes, tlast on the 12th pixel byte.
REQ-033 rst_n low during byte 30 of REQ-029 -> tvalid 0 next cycle, no done; a new start gives the full 70-byte image.
REQ-034 Macro undefined, REQ-029 window -> 16 bytes (6 pixel, 2 pad, 6 pixel, 2 pad); first readAddr 54 one cycle after start.

Source files
------------

// File: rtl/bmp_streamer.sv
// Streams a cropped image buffer as a 24-bit BMP byte stream over a valid/ready byte interface.
// Define BMP_STREAMER_HEADER_EN to prefix the 54-byte BMP header; otherwise only pixel and pad bytes are sent.
module bmp_streamer #(
    parameter int unsigned BASE_ADDR = 54,
    parameter int unsigned PPM       = 2835
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [10:0] xMin,
    input  logic [10:0] xMax,
    input  logic [10:0] yMin,
    input  logic [10:0] yMax,
    output logic [23:0] readAddr,
    input  logic [15:0] readdata,
    output logic [7:0]  tdata,
    output logic        tvalid,
    input  logic        tready,
    output logic        tlast
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_EMIT   = 3'd4;
    localparam logic [2:0] S_PAD    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [5:0]  HDR_LAST = 6'd53;
    localparam logic [23:0] BASE     = 24'(BASE_ADDR);

    logic [2:0]  state;
    logic [10:0] nx;
    logic [10:0] ny;
    logic [5:0]  hdr_idx;
    logic [12:0] col_cnt;
    logic [10:0] row_cnt;
    logic [1:0]  pad_cnt;
    logic [23:0] pix_cnt;

    logic [12:0]  row_len;
    logic [1:0]   pad_len;
    logic [12:0]  stride;
    logic [23:0]  img_size;
    logic [31:0]  file_size;
    logic [431:0] hdr_vec;
    logic [5:0]   next_hdr_idx;
    logic [8:0]   hdr_sel;
    logic [7:0]   hdr_byte;
    logic         last_row;
    logic         last_col;
    logic         xfer;
    logic         empty;
    logic         unused_readdata_hi;

    // Geometry of the latched window: pixel bytes per row, pad to a 4-byte stride.
    assign row_len   = {2'b00, ny} * 13'd3;
    assign pad_len   = 2'd0 - row_len[1:0];
    assign stride    = row_len + {11'd0, pad_len};
    assign img_size  = {13'd0, nx} * {11'd0, stride};
    assign file_size = {8'd0, img_size} + 32'd54;

    // Header laid out byte 0 in the low bits so a byte index selects it directly (little-endian fields).
    assign hdr_vec = {32'd0, 32'd0, 32'(PPM), 32'(PPM), {8'd0, img_size}, 32'd0,
                      16'd24, 16'd1, {21'd0, nx}, {21'd0, ny}, 32'd40, 32'd54, 32'd0,
                      file_size, 8'h4D, 8'h42};

    assign next_hdr_idx = hdr_idx + 6'd1;
    assign hdr_sel      = {next_hdr_idx, 3'b000};
    assign hdr_byte     = hdr_vec[hdr_sel +: 8];

    assign last_row = (row_cnt == nx - 11'd1);
    assign last_col = (col_cnt == row_len - 13'd1);
    assign xfer     = tvalid && tready;
    assign empty    = (xMax <= xMin) || (yMax <= yMin);

    assign unused_readdata_hi = ^readdata[15:8];

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            tvalid   <= 1'b0;
            tlast    <= 1'b0;
            tdata    <= 8'd0;
            readAddr <= BASE;
            nx       <= 11'd0;
            ny       <= 11'd0;
            hdr_idx  <= 6'd0;
            col_cnt  <= 13'd0;
            row_cnt  <= 11'd0;
            pad_cnt  <= 2'd0;
            pix_cnt  <= 24'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        nx      <= xMax - xMin;
                        ny      <= yMax - yMin;
                        hdr_idx <= 6'd0;
                        col_cnt <= 13'd0;
                        row_cnt <= 11'd0;
                        pad_cnt <= 2'd0;
                        if (empty) begin
                            state   <= S_DONE;
                            pix_cnt <= 24'd0;
                        end else begin
`ifdef BMP_STREAMER_HEADER_EN
                            state   <= S_HEADER;
                            tdata   <= 8'h42;
                            tvalid  <= 1'b1;
                            tlast   <= 1'b0;
                            pix_cnt <= 24'd0;
`else
                            state    <= S_FETCH;
                            readAddr <= BASE;
                            pix_cnt  <= 24'd1;
`endif
                        end
                    end
                end

                S_HEADER: begin
                    if (xfer) begin
                        if (hdr_idx == HDR_LAST) begin
                            tvalid   <= 1'b0;
                            state    <= S_FETCH;
                            readAddr <= BASE + pix_cnt;
                            pix_cnt  <= pix_cnt + 24'd1;
                        end else begin
                            hdr_idx <= next_hdr_idx;
                            tdata   <= hdr_byte;
                        end
                    end
                end

                S_FETCH: state <= S_WAIT;

                S_WAIT: begin
                    tdata  <= readdata[7:0];
                    tvalid <= 1'b1;
                    tlast  <= last_row && last_col && (pad_len == 2'd0);
                    state  <= S_EMIT;
                end

                S_EMIT: begin
                    if (xfer) begin
                        tvalid <= 1'b0;
                        tlast  <= 1'b0;
                        if (!last_col) begin
                            col_cnt  <= col_cnt + 13'd1;
                            state    <= S_FETCH;
                            readAddr <= BASE + pix_cnt;
                            pix_cnt  <= pix_cnt + 24'd1;
                        end else if (pad_len != 2'd0) begin
                            col_cnt <= 13'd0;
                            pad_cnt <= 2'd0;
                            tdata   <= 8'd0;
                            tvalid  <= 1'b1;
                            tlast   <= last_row && (pad_len == 2'd1);
                            state   <= S_PAD;
                        end else if (last_row) begin
                            state <= S_DONE;
                        end else begin
                            col_cnt  <= 13'd0;
                            row_cnt  <= row_cnt + 11'd1;
                            state    <= S_FETCH;
                            readAddr <= BASE + pix_cnt;
                            pix_cnt  <= pix_cnt + 24'd1;
                        end
                    end
                end

                S_PAD: begin
                    if (xfer) begin
                        if (pad_cnt == pad_len - 2'd1) begin
                            tvalid <= 1'b0;
                            tlast  <= 1'b0;
                            if (last_row) begin
                                state <= S_DONE;
                            end else begin
                                row_cnt  <= row_cnt + 11'd1;
                                state    <= S_FETCH;
                                readAddr <= BASE + pix_cnt;
                                pix_cnt  <= pix_cnt + 24'd1;
                            end
                        end else begin
                            pad_cnt <= pad_cnt + 2'd1;
                            tlast   <= last_row && (pad_cnt + 2'd2 == pad_len);
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_streamer.sv
// Randomized self-checking bench for bmp_streamer against a queue-based BMP stream model.
// Honours BMP_STREAMER_HEADER_EN the same way the design does.
module tb_bmp_streamer;

    localparam int BASE   = 54;
    localparam int PPM_V  = 2835;
    localparam int BUDGET = 3000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [10:0] xMin, xMax, yMin, yMax;
    logic [23:0] readAddr;
    logic [15:0] readdata;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    logic [7:0] mem [0:1023];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    bmp_streamer #(.BASE_ADDR(BASE), .PPM(PPM_V)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
        .readAddr(readAddr), .readdata(readdata),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer with one cycle of read latency; the high byte is noise the design must ignore.
    always @(posedge clk) readdata <= {8'($urandom), mem[readAddr[9:0]]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic push_le(input int v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'((v >> (8 * i)) & 255));
    endtask

    task automatic build_exp(input int x0, input int x1, input int y0, input int y1);
        int nx, ny, row, pad, stride, k;
        exp_q.delete();
        if (x1 <= x0 || y1 <= y0) return;
        nx = x1 - x0;
        ny = y1 - y0;
        row = ny * 3;
        pad = (4 - (row % 4)) % 4;
        stride = row + pad;
`ifdef BMP_STREAMER_HEADER_EN
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push_le(54 + nx * stride, 4);
        push_le(0, 4);
        push_le(54, 4);
        push_le(40, 4);
        push_le(ny, 4);
        push_le(nx, 4);
        push_le(1, 2);
        push_le(24, 2);
        push_le(0, 4);
        push_le(nx * stride, 4);
        push_le(PPM_V, 4);
        push_le(PPM_V, 4);
        push_le(0, 4);
        push_le(0, 4);
`endif
        k = 0;
        for (int r = 0; r < nx; r++) begin
            for (int c = 0; c < row; c++) begin
                exp_q.push_back(mem[BASE + k]);
                k++;
            end
            for (int p = 0; p < pad; p++) exp_q.push_back(8'h00);
        end
    endtask

    // mode 0: tready high, 1: toggles every cycle, 2: random. abort_at > 0 resets after that many bytes.
    task automatic run_image(input string tag, input int x0, input int x1, input int y0, input int y1,
                             input int mode, input bit restart_mid, input int abort_at);
        int cyc, done_cyc, last_cnt, last_idx, stall_err, bad, dones;
        bit done_seen, saw_valid, prev_stall;
        logic [7:0] prev_data;
        logic prev_last;
        bit nonempty;

        nonempty = (x1 > x0) && (y1 > y0);
        build_exp(x0, x1, y0, y1);
        got_q.delete();
        done_cyc = -1; last_cnt = 0; last_idx = -1; stall_err = 0;
        done_seen = 0; saw_valid = 0; prev_stall = 0; prev_data = 8'd0; prev_last = 1'b0;

        @(negedge clk);
        xMin = 11'(x0); xMax = 11'(x1); yMin = 11'(y0); yMax = 11'(y1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        xMin = 11'($urandom); xMax = 11'($urandom); yMin = 11'($urandom); yMax = 11'($urandom);
        if (nonempty) begin
            check({tag, " busy_after_start"}, 32'(busy), 32'd1);
`ifndef BMP_STREAMER_HEADER_EN
            check({tag, " first_readAddr"}, 32'(readAddr), 32'(BASE));
`endif
        end

        cyc = 1;
        while (!done_seen && cyc < BUDGET) begin
            if (done) begin
                done_seen = 1;
                done_cyc = cyc;
                check({tag, " busy_at_done"}, 32'(busy), 32'd0);
            end
            if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stall_err++;
            if (abort_at > 0 && got_q.size() == abort_at && tvalid) begin
                rst_n = 1'b0;
                @(negedge clk);
                check({tag, " tvalid_after_reset"}, 32'(tvalid), 32'd0);
                rst_n = 1'b1;
                dones = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (done) dones++;
                end
                check({tag, " no_done_after_abort"}, 32'(dones), 32'd0);
                return;
            end
            case (mode)
                0: tready = 1'b1;
                1: tready = (cyc % 2 == 1);
                default: tready = ($urandom_range(0, 2) != 0);
            endcase
            if (tvalid) saw_valid = 1;
            if (tvalid && tready) begin
                if (tlast) begin
                    last_cnt++;
                    last_idx = got_q.size();
                end
                got_q.push_back(tdata);
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            start = restart_mid && (cyc == 3);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        tready = 1'b1;

        check({tag, " done_seen"}, 32'(done_seen), 32'd1);
        check({tag, " byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({tag, " bad_bytes"}, 32'(bad), 32'd0);
        check({tag, " stall_violations"}, 32'(stall_err), 32'd0);
        if (nonempty) begin
            check({tag, " tlast_count"}, 32'(last_cnt), 32'd1);
            check({tag, " tlast_index"}, 32'(last_idx), 32'(exp_q.size() - 1));
        end else begin
            check({tag, " tvalid_never"}, 32'(saw_valid), 32'd0);
            check({tag, " done_latency"}, 32'(done_cyc), 32'd2);
        end
    endtask

    initial begin
        int x0, nxr, y0, nyr;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0; start = 1'b0; tready = 1'b0;
        xMin = 11'd0; xMax = 11'd0; yMin = 11'd0; yMax = 11'd0;
        repeat (3) @(negedge clk);
        check("reset tvalid", 32'(tvalid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset tlast", 32'(tlast), 32'd0);
        check("reset tdata", 32'(tdata), 32'd0);
        check("reset readAddr", 32'(readAddr), 32'(BASE));
        rst_n = 1'b1;

        run_image("win2x2", 0, 2, 0, 2, 0, 0, 0);
`ifdef BMP_STREAMER_HEADER_EN
        check("win2x2 size_total", 32'(got_q.size()), 32'd70);
        if (got_q.size() >= 26) begin
            check("win2x2 byte2", 32'(got_q[2]), 32'h46);
            check("win2x2 byte18", 32'(got_q[18]), 32'd2);
            check("win2x2 byte22", 32'(got_q[22]), 32'd2);
        end
`else
        check("win2x2 size_total", 32'(got_q.size()), 32'd16);
`endif
        run_image("win2x2_toggle", 0, 2, 0, 2, 1, 0, 0);
        run_image("empty_x", 5, 5, 0, 3, 0, 0, 0);
        run_image("empty_y", 1, 4, 7, 2, 2, 0, 0);
        run_image("ny4_nopad", 0, 1, 0, 4, 0, 0, 0);
`ifdef BMP_STREAMER_HEADER_EN
        run_image("abort", 0, 2, 0, 2, 0, 0, 30);
`else
        run_image("abort", 0, 2, 0, 2, 0, 0, 8);
`endif
        run_image("after_abort", 0, 2, 0, 2, 0, 0, 0);
        run_image("restart_ignored", 3, 5, 10, 13, 2, 1, 0);

        for (int t = 0; t < 8; t++) begin
            nxr = $urandom_range(1, 4);
            nyr = $urandom_range(1, 7);
            x0  = $urandom_range(0, 2040);
            y0  = $urandom_range(0, 2040);
            run_image($sformatf("rand%0d", t), x0, x0 + nxr, y0, y0 + nyr,
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
